// File: rtl/reg_file_master_if.sv
// ---------------------------------------------------------------------------
// reg_file_master_if
//   Command / response bundle between a host controller and reg_file_master.
//   One command is offered per handshake (cmd_valid && cmd_ready); the block
//   answers with a single-cycle rsp_valid pulse that cannot be back-pressured.
//
//   Signals
//     cmd_valid  host -> block   command present
//     cmd_ready  block -> host   block idle and able to accept
//     cmd_op     host -> block   00 WRITE, 01 READ, 10 ALU, 11 FILL
//     cmd_rd     host -> block   destination / FILL end index
//     cmd_rs     host -> block   source A / FILL start index
//     cmd_rt     host -> block   source B (ALU)
//     cmd_data   host -> block   WRITE data / FILL base / ALU func in [1:0]
//     rsp_valid  block -> host   completion pulse
//     rsp_data   block -> host   result value
//     rsp_zero   block -> host   rsp_data == 0
//
//   Modports: master = host side, slave = reg_file_master side.
// ---------------------------------------------------------------------------
interface reg_file_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/reg_file_master.sv
// ---------------------------------------------------------------------------
// reg_file_master
//   Command-driven initiator for a 32x32 register file. Accepts one command
//   at a time and turns it into register-file port activity:
//     WRITE  R[rd] = data
//     READ   returns R[rs]
//     ALU    R[rd] = R[rs] op R[rt]   (op = data[1:0]: add, sub, and, or)
//     FILL   R[rs..rd] = base, base+FILL_STEP, ...  (one write per cycle)
//
//   Ports
//     clk_Regs   clock shared with the register file
//     rst_n      asynchronous active-low reset (aborts any command in flight)
//     host       command / response bundle (slave side)
//     Reg_Write  register-file write enable
//     R_Addr_A   read port A address (= rs of the current command)
//     R_Addr_B   read port B address (= rt of the current command)
//     W_Addr     write address
//     W_Data     write data
//     R_Data_A   read port A data (combinational from the register file)
//     R_Data_B   read port B data
// ---------------------------------------------------------------------------
module reg_file_master #(
  parameter logic [31:0] FILL_STEP = 32'd1
) (
  input  logic                    clk_Regs,
  input  logic                    rst_n,
  reg_file_master_if.slave        host,
  output logic                    Reg_Write,
  output logic [4:0]              R_Addr_A,
  output logic [4:0]              R_Addr_B,
  output logic [4:0]              W_Addr,
  output logic [31:0]             W_Data,
  input  logic [31:0]             R_Data_A,
  input  logic [31:0]             R_Data_B
);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, RSP} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_ALU   = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  state_t      state, state_next;

  logic [1:0]  op;
  logic [4:0]  rd, rs, rt;
  logic [31:0] data;
  logic [31:0] opa, opb;
  logic [4:0]  idx;
  logic [31:0] fill_val;
  logic [31:0] rsp_data_q;
  logic        rsp_zero_q;

  logic [31:0] alu_result;
  logic        fill_nonempty;
  logic [5:0]  fill_count;

  // Operands come from the RD-stage capture, so rd aliasing rs/rt sees old values.
  always_comb begin
    alu_result = opa + opb;
    case (data[1:0])
      2'b00:   alu_result = opa + opb;
      2'b01:   alu_result = opa - opb;
      2'b10:   alu_result = opa & opb;
      default: alu_result = opa | opb;
    endcase
  end

  assign fill_nonempty = (rs <= rd);
  assign fill_count    = fill_nonempty ? (({1'b0, rd} - {1'b0, rs}) + 6'd1) : 6'd0;

  // Addresses are the latched command fields; they reset to zero.
  assign R_Addr_A = rs;
  assign R_Addr_B = rt;
  assign W_Addr   = (state == FILL) ? idx : rd;
  assign W_Data   = (state == FILL) ? fill_val : ((op == OP_ALU) ? alu_result : data);

  assign host.rsp_data = rsp_data_q;
  assign host.rsp_zero = rsp_zero_q;

  always_ff @(posedge clk_Regs or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    Reg_Write      = 1'b0;
    host.cmd_ready = 1'b0;
    host.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        host.cmd_ready = 1'b1;
        if (host.cmd_valid) begin
          case (host.cmd_op)
            OP_WRITE: state_next = WR;
            OP_FILL:  state_next = FILL;
            default:  state_next = RD;
          endcase
        end
      end
      RD:   state_next = (op == OP_ALU) ? WR : RSP;
      WR: begin
        Reg_Write  = 1'b1;
        state_next = RSP;
      end
      FILL: begin
        // An inverted range spends a single cycle here without writing.
        Reg_Write  = fill_nonempty;
        state_next = (idx < rd) ? FILL : RSP;
      end
      RSP: begin
        host.rsp_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_Regs or negedge rst_n) begin
    if (!rst_n) begin
      op         <= 2'b00;
      rd         <= 5'd0;
      rs         <= 5'd0;
      rt         <= 5'd0;
      data       <= 32'd0;
      opa        <= 32'd0;
      opb        <= 32'd0;
      idx        <= 5'd0;
      fill_val   <= 32'd0;
      rsp_data_q <= 32'd0;
      rsp_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host.cmd_valid) begin
            op       <= host.cmd_op;
            rd       <= host.cmd_rd;
            rs       <= host.cmd_rs;
            rt       <= host.cmd_rt;
            data     <= host.cmd_data;
            idx      <= host.cmd_rs;
            fill_val <= host.cmd_data;
          end
        end
        RD: begin
          opa <= R_Data_A;
          opb <= R_Data_B;
          if (op == OP_READ) begin
            rsp_data_q <= R_Data_A;
            rsp_zero_q <= (R_Data_A == 32'd0);
          end
        end
        WR: begin
          rsp_data_q <= W_Data;
          rsp_zero_q <= (W_Data == 32'd0);
        end
        FILL: begin
          if (idx < rd) begin
            idx      <= idx + 5'd1;
            fill_val <= fill_val + FILL_STEP;
          end else begin
            rsp_data_q <= {26'd0, fill_count};
            rsp_zero_q <= (fill_count == 6'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
